// File: rtl/phase_sequencer.sv
// Demand-actuated N-phase signal sequencer: GREEN -> YELLOW -> ALL_RED,
// round-robin service of latched car/pedestrian demand.
module phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int TICKS_PER_SEC = 1000,
    parameter int TIMER_W = 8,
    parameter int GREEN_MAX = 120,
    parameter int GREEN_MIN = 30,
    parameter int YELLOW_TIME = 4,
    parameter int ALL_RED_TIME = 2,
    parameter int PED_CLEAR = 10,
    parameter logic [NUM_PHASES-1:0] PED_MASK = 4'b0101,
    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PHASES-1:0] car_req_i,
    input  logic [NUM_PHASES-1:0] ped_req_i,
    output logic [NUM_PHASES-1:0] green_o,
    output logic [NUM_PHASES-1:0] yellow_o,
    output logic [NUM_PHASES-1:0] red_o,
    output logic [NUM_PHASES-1:0] walk_o,
    output logic [NUM_PHASES-1:0] hand_o,
    output logic [PW-1:0]         active_phase_o,
    output logic [TIMER_W-1:0]    countdown_o,
    output logic                  sec_tick_o
);

    typedef enum logic [1:0] {
        S_GREEN,
        S_YELLOW,
        S_ALLRED
    } state_e;

    localparam int PSW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(TICKS_PER_SEC - 1);
    localparam logic [TIMER_W-1:0] T_ONE = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] T_GMAX = TIMER_W'(GREEN_MAX);
    localparam logic [TIMER_W-1:0] T_GMIN = TIMER_W'(GREEN_MIN);
    localparam logic [TIMER_W-1:0] T_YEL = TIMER_W'(YELLOW_TIME);
    localparam logic [TIMER_W-1:0] T_AR = TIMER_W'(ALL_RED_TIME);
    localparam logic [TIMER_W-1:0] T_PCLR = TIMER_W'(PED_CLEAR);

    state_e                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [PW-1:0]         next_q, next_d;
    logic [TIMER_W-1:0]    cnt_q, cnt_d;
    logic [PSW-1:0]        presc_q, presc_d;
    logic [NUM_PHASES-1:0] pend_q, pend_d;
    logic [NUM_PHASES-1:0] pped_q, pped_d;
    logic                  wgrant_q, wgrant_d;

    logic                  tick;
    logic                  expire;
    logic [NUM_PHASES-1:0] act_oh, nxt_oh;
    logic [NUM_PHASES-1:0] req_car, req_ped, ign, others;
    logic [PW-1:0]         rr_idx, rr_sel;
    logic                  rr_found;

    always_comb begin
        tick    = (presc_q == PS_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // First pending phase strictly after the active one, wrapping around.
    always_comb begin
        rr_sel   = phase_q;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k < NUM_PHASES; k++) begin
            rr_idx = PW'((int'(phase_q) + k) % NUM_PHASES);
            if (!rr_found && pend_q[rr_idx]) begin
                rr_sel   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        act_oh  = NUM_PHASES'(1) << phase_q;
        nxt_oh  = NUM_PHASES'(1) << next_q;
        others  = pend_q & ~act_oh;
        expire  = tick && (cnt_q == T_ONE);
        req_ped = ped_req_i & PED_MASK;
        req_car = car_req_i | req_ped;
        ign     = (state_q == S_GREEN) ? act_oh : '0;

        state_d  = state_q;
        phase_d  = phase_q;
        next_d   = next_q;
        wgrant_d = wgrant_q;
        cnt_d    = tick ? cnt_q - T_ONE : cnt_q;
        pend_d   = pend_q | (req_car & ~ign);
        pped_d   = pped_q | (req_ped & ~ign);

        unique case (state_q)
            S_GREEN: begin
                if ((others != '0) && (cnt_q > T_GMIN)) begin
                    cnt_d = T_GMIN;
                end else if (expire) begin
                    if (others == '0) begin
                        cnt_d = T_GMAX;
                    end else begin
                        next_d  = rr_sel;
                        state_d = S_YELLOW;
                        cnt_d   = T_YEL;
                    end
                end
            end
            S_YELLOW: begin
                if (expire) begin
                    state_d = S_ALLRED;
                    cnt_d   = T_AR;
                end
            end
            S_ALLRED: begin
                if (expire) begin
                    state_d  = S_GREEN;
                    phase_d  = next_q;
                    cnt_d    = T_GMAX;
                    wgrant_d = pped_q[next_q];
                    // Clearing on entry beats any request arriving now.
                    pend_d   = pend_d & ~nxt_oh;
                    pped_d   = pped_d & ~nxt_oh;
                end
            end
            default: begin
                state_d = S_GREEN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_GREEN;
            phase_q  <= '0;
            next_q   <= '0;
            cnt_q    <= T_GMAX;
            presc_q  <= '0;
            pend_q   <= '0;
            pped_q   <= '0;
            wgrant_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            next_q   <= next_d;
            cnt_q    <= cnt_d;
            presc_q  <= presc_d;
            pend_q   <= pend_d;
            pped_q   <= pped_d;
            wgrant_q <= wgrant_d;
        end
    end

    always_comb begin
        green_o  = (state_q == S_GREEN) ? act_oh : '0;
        yellow_o = (state_q == S_YELLOW) ? act_oh : '0;
        red_o    = ~(green_o | yellow_o);
        walk_o   = green_o & PED_MASK
                 & {NUM_PHASES{wgrant_q && (cnt_q > T_PCLR)}};
        hand_o   = ~walk_o;
    end

    assign active_phase_o = phase_q;
    assign countdown_o    = cnt_q;
    assign sec_tick_o     = tick;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer using small timing constants.
module tb_phase_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] car_req;
    logic [3:0] ped_req;
    logic [3:0] green, yellow, red, walk, hand;
    logic [1:0] active;
    logic [7:0] cd;
    logic       tick;

    int n_cmp;
    int n_bad;
    int t;

    phase_sequencer #(
        .NUM_PHASES(4),
        .TICKS_PER_SEC(4),
        .TIMER_W(8),
        .GREEN_MAX(10),
        .GREEN_MIN(3),
        .YELLOW_TIME(2),
        .ALL_RED_TIME(1),
        .PED_CLEAR(2),
        .PED_MASK(4'b0101)
    ) dut (
        .clk(clk),
        .rst(rst),
        .car_req_i(car_req),
        .ped_req_i(ped_req),
        .green_o(green),
        .yellow_o(yellow),
        .red_o(red),
        .walk_o(walk),
        .hand_o(hand),
        .active_phase_o(active),
        .countdown_o(cd),
        .sec_tick_o(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    task automatic goto(input int tt);
        adv(tt - t);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        t       = 0;
        rst     = 1'b1;
        car_req = '0;
        ped_req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t   = 0;

        chk("rst_green", green, 4'b0001);
        chk("rst_red", red, 4'b1110);
        chk("rst_yellow", yellow, 4'b0000);
        chk("rst_walk", walk, 4'b0000);
        chk("rst_hand", hand, 4'b1111);
        chk("rst_active", active, 0);
        chk("rst_cd", cd, 10);

        // rest in green for 100 seconds
        for (int s = 0; s < 100; s++) begin
            chk("t1_cd", cd, 10 - (s % 10));
            chk("t1_green", green, 4'b0001);
            chk("t1_yellow", yellow, 4'b0000);
            chk("t1_tick_lo", tick, 0);
            adv(3);
            chk("t1_tick_hi", tick, 1);
            adv(1);
        end

        // truncation and skipping of phase 1
        goto(408);
        chk("t2_cd8", cd, 8);
        car_req = 4'b0100;
        adv(1);
        car_req = '0;
        chk("t2_cd8b", cd, 8);
        adv(1);
        chk("t2_trunc", cd, 3);
        goto(418);
        chk("t2_green0", green, 4'b0001);
        chk("t2_cd1", cd, 1);
        goto(421);
        chk("t2_yel", yellow, 4'b0001);
        chk("t2_yel_g", green, 4'b0000);
        chk("t2_yel_r", red, 4'b1110);
        chk("t2_yel_cd", cd, 2);
        goto(425);
        chk("t2_yel2", yellow, 4'b0001);
        chk("t2_yel2_cd", cd, 1);
        goto(429);
        chk("t2_ar_r", red, 4'b1111);
        chk("t2_ar_y", yellow, 4'b0000);
        chk("t2_ar_g", green, 4'b0000);
        goto(433);
        chk("t2_g2", green, 4'b0100);
        chk("t2_act2", active, 2);
        chk("t2_cd10", cd, 10);
        chk("t2_walk", walk, 4'b0000);
        chk("t2_pend", dut.pend_q, 4'b0000);

        // round robin: 3 before 0
        car_req = 4'b1001;
        adv(1);
        car_req = '0;
        goto(435);
        chk("t3_trunc", cd, 3);
        goto(445);
        chk("t3_yel", yellow, 4'b0100);
        goto(453);
        chk("t3_ar", red, 4'b1111);
        goto(456);
        chk("t3_g3", green, 4'b1000);
        chk("t3_act3", active, 3);
        chk("t3_cd10", cd, 10);
        goto(458);
        chk("t3_trunc3", cd, 3);
        goto(469);
        chk("t3_yel3", yellow, 4'b1000);
        goto(481);
        chk("t3_g0", green, 4'b0001);
        chk("t3_act0", active, 0);
        chk("t3_walk0", walk, 4'b0000);

        // pedestrian walk, phase 1 button masked
        ped_req = 4'b0110;
        adv(1);
        ped_req = '0;
        chk("t4_pend", dut.pend_q, 4'b0100);
        goto(483);
        chk("t4_trunc", cd, 3);
        goto(493);
        chk("t4_yel0", yellow, 4'b0001);
        goto(505);
        chk("t4_g2", green, 4'b0100);
        chk("t4_act2", active, 2);
        chk("t4_walk", walk, 4'b0100);
        chk("t4_hand", hand, 4'b1011);
        goto(533);
        chk("t4_cd3", cd, 3);
        chk("t4_walk3", walk, 4'b0100);
        goto(537);
        chk("t4_cd2", cd, 2);
        chk("t4_walk2", walk, 4'b0000);
        chk("t4_hand2", hand, 4'b1111);
        goto(541);
        chk("t4_cd1", cd, 1);
        chk("t4_walk1", walk, 4'b0000);
        goto(545);
        chk("t4_rest_cd", cd, 10);
        chk("t4_rest_g", green, 4'b0100);
        chk("t4_rest_walk", walk, 4'b0100);

        // request coincident with green entry
        car_req = 4'b0001;
        adv(1);
        car_req = '0;
        goto(569);
        chk("t5_g0", green, 4'b0001);
        chk("t5_act0", active, 0);
        car_req = 4'b0100;
        adv(1);
        car_req = '0;
        goto(581);
        chk("t5_yel0", yellow, 4'b0001);
        goto(591);
        chk("t5_ar", red, 4'b1111);
        chk("t5_ar_cd", cd, 1);
        car_req = 4'b0100;
        adv(2);
        car_req = '0;
        chk("t5_g2", green, 4'b0100);
        chk("t5_act2", active, 2);
        adv(1);
        chk("t5_pend", dut.pend_q, 4'b0000);
        chk("t5_cd10", cd, 10);
        goto(633);
        chk("t5_rest_g", green, 4'b0100);
        chk("t5_rest_cd", cd, 10);
        chk("t5_rest_y", yellow, 4'b0000);

        // asynchronous reset during yellow
        car_req = 4'b1000;
        adv(1);
        car_req = '0;
        goto(645);
        chk("t6_yel", yellow, 4'b0100);
        chk("t6_yel_cd", cd, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ar_green", green, 4'b0001);
        chk("t6_ar_yellow", yellow, 4'b0000);
        chk("t6_ar_red", red, 4'b1110);
        chk("t6_ar_walk", walk, 4'b0000);
        chk("t6_ar_hand", hand, 4'b1111);
        chk("t6_ar_act", active, 0);
        chk("t6_ar_cd", cd, 10);
        chk("t6_ar_tick", tick, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
        chk("t6_presc", dut.presc_q, 0);
        chk("t6_cd10", cd, 10);
        chk("t6_green", green, 4'b0001);
        adv(3);
        chk("t6_tick", tick, 1);
        chk("t6_cd10b", cd, 10);
        adv(1);
        chk("t6_cd9", cd, 9);
        chk("t6_green2", green, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
